// File: rtl/filtro_pkg.sv
// Shared constants and FSM encoding for the 9-tap MAC filter.
package filtro_pkg;

  localparam int unsigned NTAPS     = 9;
  localparam int unsigned IDX_W     = 4;
  localparam int unsigned ACC_GUARD = 4;
  localparam int unsigned DW_DEF    = 16;
  localparam int unsigned ACC_W     = 2 * DW_DEF + ACC_GUARD;

  typedef logic [1:0] state_t;

  localparam state_t IDLE = 2'd0;
  localparam state_t MAC  = 2'd1;
  localparam state_t DONE = 2'd2;

  // Accumulator width for a given sample width: full product plus guard bits for 9 taps.
  function automatic int unsigned acc_width(input int unsigned dw);
    return 2 * dw + ACC_GUARD;
  endfunction

endpackage

// File: rtl/filtro_linea.sv
// 9-entry sample delay line: shifts on enable, one indexed combinational read port.
module filtro_linea
  import filtro_pkg::*;
#(
  parameter int DW = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              en,
  input  logic [DW-1:0]     din,
  input  logic [IDX_W-1:0]  rd_idx,
  output logic [DW-1:0]     rd_data_c
);

  logic [DW-1:0] x [NTAPS];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < int'(NTAPS); i++) x[i] <= '0;
    end else if (en) begin
      x[0] <= din;
      for (int i = 1; i < int'(NTAPS); i++) x[i] <= x[i-1];
    end
  end

  always_comb begin
    rd_data_c = '0;
    if (rd_idx < IDX_W'(NTAPS)) rd_data_c = x[rd_idx];
  end

endmodule

// File: rtl/filtro_mac.sv
// 9-tap FIR multiply-accumulate engine: one tap per cycle, Q1.15 coefficients, saturated output.
module filtro_mac
  import filtro_pkg::*;
#(
  parameter int DW   = 16,
  parameter int FRAC = 15
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          we_d,
  input  logic [31:0]   din,
  input  logic          we_k,
  input  logic [3:0]    k_addr,
  input  logic [DW-1:0] k_data,
  input  logic          inicio,
  output logic          conto9,
  output logic          busy,
  output logic          done,
  output logic [31:0]   result,
  output logic          ovf
);

  localparam int unsigned AW = acc_width(DW);
  localparam int unsigned PW = 2 * DW;
  localparam logic [IDX_W-1:0] LAST_TAP = IDX_W'(NTAPS - 1);
  localparam logic signed [AW-1:0] SAT_MAX = {{(AW-DW+1){1'b0}}, {(DW-1){1'b1}}};
  localparam logic signed [AW-1:0] SAT_MIN = {{(AW-DW+1){1'b1}}, {(DW-1){1'b0}}};

  state_t state, state_nx;

  logic [3:0]              count;
  logic [IDX_W-1:0]        tap;
  logic signed [DW-1:0]    k     [NTAPS];
  logic signed [DW-1:0]    k_act [NTAPS];
  logic signed [AW-1:0]    acc;

  logic                    start_c;
  logic                    shift_c;
  logic [DW-1:0]           x_tap_c;
  logic signed [PW-1:0]    prod_c;
  logic signed [AW-1:0]    shr_c;
  logic signed [DW-1:0]    sat_c;
  logic                    clip_c;
  logic                    unused_din_c;

  assign unused_din_c = ^din[31:DW];

  // A start request takes priority over a simultaneous sample write.
  assign start_c = (state == IDLE) && inicio && conto9;
  assign shift_c = (state == IDLE) && we_d && !start_c;

  filtro_linea #(.DW(DW)) u_linea (
    .clk       (clk),
    .reset     (reset),
    .en        (shift_c),
    .din       (din[DW-1:0]),
    .rd_idx    (tap),
    .rd_data_c (x_tap_c)
  );

  assign prod_c = PW'($signed(x_tap_c)) * PW'(k_act[tap]);
  assign shr_c  = acc >>> FRAC;

  always_comb begin
    sat_c  = shr_c[DW-1:0];
    clip_c = 1'b0;
    if (shr_c > SAT_MAX) begin
      sat_c  = SAT_MAX[DW-1:0];
      clip_c = 1'b1;
    end else if (shr_c < SAT_MIN) begin
      sat_c  = SAT_MIN[DW-1:0];
      clip_c = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start_c) state_nx = MAC;
      MAC:     if (tap == LAST_TAP) state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Coefficient bank is writable anytime; the MAC works on a snapshot taken at start.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < int'(NTAPS); i++) begin
        k[i]     <= '0;
        k_act[i] <= '0;
      end
      count  <= '0;
      conto9 <= 1'b0;
      tap    <= '0;
      acc    <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
      result <= '0;
      ovf    <= 1'b0;
    end else begin
      busy <= (state_nx == MAC);
      done <= (state == DONE);
      if (we_k && (k_addr <= LAST_TAP)) k[k_addr] <= k_data;
      case (state)
        IDLE: begin
          if (start_c) begin
            acc   <= '0;
            tap   <= '0;
            k_act <= k;
          end else if (shift_c && (count != 4'd9)) begin
            count  <= count + 4'd1;
            conto9 <= (count == 4'd8);
          end
        end
        MAC: begin
          acc <= acc + AW'(prod_c);
          if (tap != LAST_TAP) tap <= tap + IDX_W'(1);
        end
        DONE: begin
          result <= 32'(sat_c);
          ovf    <= clip_c;
          count  <= '0;
          conto9 <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_filtro_mac.sv
// Directed self-checking bench for filtro_mac with hand-computed expected results.
module tb_filtro_mac;

  logic        clk = 1'b0;
  logic        reset;
  logic        we_d;
  logic [31:0] din;
  logic        we_k;
  logic [3:0]  k_addr;
  logic [15:0] k_data;
  logic        inicio;
  logic        conto9;
  logic        busy;
  logic        done;
  logic [31:0] result;
  logic        ovf;

  int n_vec = 0;
  int n_bad = 0;

  filtro_mac #(.DW(16), .FRAC(15)) dut (
    .clk    (clk),
    .reset  (reset),
    .we_d   (we_d),
    .din    (din),
    .we_k   (we_k),
    .k_addr (k_addr),
    .k_data (k_data),
    .inicio (inicio),
    .conto9 (conto9),
    .busy   (busy),
    .done   (done),
    .result (result),
    .ovf    (ovf)
  );

  always #5 clk = ~clk;

  task automatic check_vec(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %08h expected %08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_sample(input logic [15:0] v);
    we_d = 1'b1;
    din  = {16'hABCD, v};
    tick();
    we_d = 1'b0;
  endtask

  task automatic write_k(input logic [3:0] a, input logic [15:0] v);
    we_k   = 1'b1;
    k_addr = a;
    k_data = v;
    tick();
    we_k = 1'b0;
  endtask

  task automatic set_all_k(input logic [15:0] v);
    for (int i = 0; i < 9; i++) write_k(4'(i), v);
  endtask

  // Starts a computation and checks latency, single done pulse and result.
  // With interfere set, we_d/inicio are held through MAC/DONE and k[0] is rewritten mid-run.
  task automatic run_mac(input string tag, input logic [31:0] exp_res, input logic exp_ovf,
                         input bit interfere);
    int lat;
    int pulses;
    logic [31:0] res_seen;
    logic        ovf_seen;
    lat      = 0;
    pulses   = 0;
    res_seen = '0;
    ovf_seen = 1'b0;
    inicio = 1'b1;
    if (interfere) begin
      we_d = 1'b1;
      din  = 32'h0000_1234;
    end
    tick();
    inicio = 1'b0;
    we_d   = 1'b0;
    check_vec({tag, "_busy"}, 32'(busy), 32'd1);
    for (int cyc = 1; cyc <= 30; cyc++) begin
      if (interfere && cyc <= 10) begin
        we_d   = 1'b1;
        inicio = 1'b1;
        din    = 32'h0000_1234;
        we_k   = (cyc == 2);
        k_addr = 4'd0;
        k_data = 16'h7FFF;
      end else begin
        we_d   = 1'b0;
        inicio = 1'b0;
        we_k   = 1'b0;
      end
      tick();
      if (done) begin
        pulses++;
        if (lat == 0) begin
          lat      = cyc;
          res_seen = result;
          ovf_seen = ovf;
        end
      end
    end
    check_vec({tag, "_latency"}, 32'(lat), 32'd10);
    check_vec({tag, "_pulses"}, 32'(pulses), 32'd1);
    check_vec({tag, "_result"}, res_seen, exp_res);
    check_vec({tag, "_ovf"}, 32'(ovf_seen), 32'(exp_ovf));
    check_vec({tag, "_result_held"}, result, exp_res);
    check_vec({tag, "_conto9"}, 32'(conto9), 32'd0);
  endtask

  initial begin
    int any_busy;
    int any_done;
    reset  = 1'b0;
    we_d   = 1'b0;
    din    = '0;
    we_k   = 1'b0;
    k_addr = '0;
    k_data = '0;
    inicio = 1'b0;
    tick();
    tick();
    check_vec("rst_result", result, 32'd0);
    check_vec("rst_flags", {28'd0, conto9, busy, done, ovf}, 32'd0);
    reset = 1'b1;
    tick();

    // Single tap: k[4]=0.5, x[4]=5 -> 2.5 floors to 2.
    write_k(4'd4, 16'h4000);
    for (int i = 1; i <= 9; i++) write_sample(16'(i));
    check_vec("single_conto9", 32'(conto9), 32'd1);
    run_mac("single", 32'd2, 1'b0, 1'b0);

    // Too few samples: start request ignored.
    for (int i = 1; i <= 5; i++) write_sample(16'(i));
    any_busy = 0;
    any_done = 0;
    inicio = 1'b1;
    for (int c = 0; c < 15; c++) begin
      tick();
      if (busy) any_busy++;
      if (done) any_done++;
    end
    inicio = 1'b0;
    check_vec("short_busy", 32'(any_busy), 32'd0);
    check_vec("short_done", 32'(any_done), 32'd0);
    check_vec("short_conto9", 32'(conto9), 32'd0);
    for (int i = 6; i <= 9; i++) write_sample(16'(i));
    check_vec("short_conto9_full", 32'(conto9), 32'd1);
    write_k(4'd12, 16'h7FFF);
    run_mac("after_short", 32'd2, 1'b0, 1'b0);

    // Saturation both directions.
    set_all_k(16'h7FFF);
    for (int i = 0; i < 9; i++) write_sample(16'h7FFF);
    run_mac("sat_pos", 32'h0000_7FFF, 1'b1, 1'b0);
    for (int i = 0; i < 9; i++) write_sample(16'h8000);
    run_mac("sat_neg", 32'hFFFF_8000, 1'b1, 1'b0);

    // Arithmetic shift floors: -3 * 0.5 = -1.5 -> -2.
    set_all_k(16'h0000);
    write_k(4'd0, 16'h4000);
    for (int i = 0; i < 8; i++) write_sample(16'h0000);
    write_sample(16'hFFFD);
    run_mac("neg_floor", 32'hFFFF_FFFE, 1'b0, 1'b0);

    // k0=0.25, k8=-1, x0=90, x8=10: 22.5-10 = 12.5 -> 12; interference must not disturb it.
    write_k(4'd0, 16'h2000);
    write_k(4'd8, 16'h8000);
    for (int i = 1; i <= 9; i++) write_sample(16'(10 * i));
    run_mac("busy_ignore", 32'd12, 1'b0, 1'b1);

    // k0 rewritten to 0x7FFF mid-run now applies: (90*32767 - 10*32768)/32768 -> 79.
    for (int i = 1; i <= 9; i++) write_sample(16'(10 * i));
    run_mac("k_deferred", 32'd79, 1'b0, 1'b0);

    // Abort in the middle of MAC.
    set_all_k(16'h7FFF);
    for (int i = 0; i < 9; i++) write_sample(16'h0100);
    inicio = 1'b1;
    tick();
    inicio = 1'b0;
    tick();
    tick();
    tick();
    check_vec("abort_busy_pre", 32'(busy), 32'd1);
    reset = 1'b0;
    #1;
    check_vec("abort_result", result, 32'd0);
    check_vec("abort_flags", {28'd0, conto9, busy, done, ovf}, 32'd0);
    tick();
    tick();
    reset = 1'b1;
    any_busy = 0;
    any_done = 0;
    for (int c = 0; c < 20; c++) begin
      tick();
      if (busy) any_busy++;
      if (done) any_done++;
    end
    check_vec("abort_busy_post", 32'(any_busy), 32'd0);
    check_vec("abort_done_post", 32'(any_done), 32'd0);
    check_vec("abort_conto9", 32'(conto9), 32'd0);
    for (int i = 0; i < 9; i++) write_sample(16'h0100);
    run_mac("k_cleared", 32'd0, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/filtro_mac.md
FILTRO_MAC -- requirements
Module: filtro_mac

Interface
REQ-001 The block SHALL have parameter DW, 16, sample and coefficient width (signed, two's complement).
REQ-002 The block SHALL have parameter FRAC, 15, number of fractional bits in coefficients (Q1.15).
REQ-003 The block SHALL have port clk  input  1  rising-edge clock.
REQ-004 The block SHALL have port reset  input  1  reset, asynchronous, active-low.
REQ-005 The block SHALL have port we_d  input  1  sample write strobe (from filter FSM).
REQ-006 The block SHALL have port din  input  32  sample bus; din[DW-1:0] is used.
REQ-007 The block SHALL have port we_k  input  1  coefficient write strobe.
REQ-008 The block SHALL have port k_addr  input  4  coefficient index 0..8.
REQ-009 The block SHALL have port k_data  input  DW  coefficient value.
REQ-010 The block SHALL have port inicio  input  1  start-computation request (from filter FSM).
REQ-011 The block SHALL have port conto9  output  1  high while 9 samples are buffered.
REQ-012 The block SHALL have port busy  output  1  high during MAC state.
REQ-013 The block SHALL have port done  output  1  one-cycle pulse when result is valid.
REQ-014 The block SHALL have port result  output  32  saturated DW-bit result, sign-extended to 32.
REQ-015 The block SHALL have port ovf  output  1  saturation occurred in the last computation.

Function
REQ-016 On we_d in IDLE, the block SHALL shift the delay line: x[0]<=din[DW-1:0], x[i]<=x[i-1] for i=1..8.
REQ-017 A sample counter SHALL increment per accepted we_d, saturating at 9; conto9 = (count==9).
REQ-018 On we_k with k_addr<=8, k[k_addr]<=k_data in any state; k_addr 9..15 SHALL be ignored.
REQ-019 FSM states SHALL be IDLE, MAC, DONE.
REQ-020 IDLE->MAC SHALL occur when inicio=1 and conto9=1; acc and tap index cleared to 0 on entry.
REQ-021 inicio with conto9=0 SHALL be ignored (stay IDLE, no done).
REQ-022 In MAC, each cycle acc <= acc + x[i]*k[i], i = 0..8; after i=8, MAC->DONE.
REQ-023 Product SHALL be 2*DW-bit signed; acc SHALL be 2*DW+4 bits signed (no internal overflow).
REQ-024 In DONE: result <= sat(acc >>> FRAC) to [-2^(DW-1), 2^(DW-1)-1], ovf <= (clipped), done=1 for one cycle, sample counter cleared to 0, DONE->IDLE.
REQ-025 Latency: inicio accepted at edge N -> done high in cycle after edge N+10; result/ovf stable until next DONE.
REQ-026 we_d and inicio during MAC or DONE SHALL be ignored (delay line frozen, counter unchanged).
REQ-027 Simultaneous we_d and inicio in IDLE with conto9=1: start wins, sample ignored.
REQ-028 Simultaneous we_k on tap i during MAC: new value SHALL apply only from the next computation (coefficients latched at MAC entry or write deferred).

Reset
REQ-029 On reset low: state=IDLE, delay line, coefficients, counter, acc, result=0, conto9=0, busy=0, done=0, ovf=0.
REQ-030 Reset mid-MAC SHALL abort immediately; no done pulse follows release.

Structure
REQ-031 Package filtro_pkg SHALL hold the state enum (IDLE, MAC, DONE), NTAPS=9, and accumulator width constant.
REQ-032 The 9-entry delay line SHALL be sub-module filtro_linea (shift on enable, indexed read port).

Verification
REQ-033 Reset: drive reset=0 mid-traffic -> all outputs 0 within same cycle, state IDLE.
REQ-034 Single tap: k[4]=0x4000, others 0; write samples 1..9 (x[4]=5); inicio -> done 10 cycles later, result=2, ovf=0, conto9=0 after.
REQ-035 Positive saturation: all k=0x7FFF, all samples 0x7FFF -> result=0x00007FFF, ovf=1; negative: samples 0x8000 -> result=0xFFFF8000, ovf=1.
REQ-036 Insufficient data: 5 samples then inicio -> busy stays 0, no done; 4 more samples -> conto9=1.
REQ-037 Ignore during busy: we_d=1 with din=0x1234 and inicio=1 during MAC -> delay line unchanged, exactly one done pulse, result matches golden model.
REQ-038 Abort: reset low at MAC cycle 4, release -> busy=0, done never pulses, conto9=0, k[] cleared to 0.
